// File: rtl/uart_buf_sched.sv
// Scheduler for the shared UART byte buffer: circular FIFO writes from the receiver, paced pops to the transmitter.
// Optional almost-full flag built only when UART_BUF_ALMOST_FULL_EN is defined.
module uart_buf_sched #(
    parameter int DW       = 8,
    parameter int AW       = 10,
    parameter int AF_LEVEL = 1000
) (
    input  logic          clk_r,
    input  logic          rst_n,
    input  logic          rx_wr_req,
    input  logic [DW-1:0] rx_wr_data,
    output logic          rx_wr_ack,
    input  logic          tx_busy,
    output logic          tx_start,
    output logic [DW-1:0] tx_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic          almost_full
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [2:0] {
        T_IDLE,
        T_READ,
        T_LAUNCH,
        T_WAIT_BUSY,
        T_WAIT_DONE
    } tstate_t;

    tstate_t       state;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] mem_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt_nxt;
    logic          wr_acc;
    logic          rd_go;
    logic          pop;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign wr_acc = rx_wr_req && !full;
    // A write strobe always owns the single memory port, so the read start yields to it.
    assign rd_go  = (state == T_IDLE) && !empty && !tx_busy && !rx_wr_req;
    assign pop    = (state == T_READ);

    always_comb begin
        cnt_nxt = count;
        case ({wr_acc, pop})
            2'b10:   cnt_nxt = count + CNT_ONE;
            2'b01:   cnt_nxt = count - CNT_ONE;
            default: cnt_nxt = count;
        endcase
    end

    always_ff @(posedge clk_r) begin
        if (wr_acc)
            mem[wr_ptr] <= rx_wr_data;
        else if (rd_go)
            mem_q <= mem[rd_ptr];
    end

    always_ff @(posedge clk_r or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            count     <= '0;
            rx_wr_ack <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            rx_wr_ack <= wr_acc;
            count     <= cnt_nxt;
            if (wr_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            // A dropped write in the same cycle as a clear keeps the flag set.
            if (rx_wr_req && full)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_r or negedge rst_n) begin
        if (!rst_n) begin
            state    <= T_IDLE;
            rd_ptr   <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                T_IDLE: begin
                    if (rd_go)
                        state <= T_READ;
                end
                T_READ: begin
                    tx_data  <= mem_q;
                    rd_ptr   <= rd_ptr + PTR_ONE;
                    tx_start <= 1'b1;
                    state    <= T_LAUNCH;
                end
                T_LAUNCH: begin
                    state <= T_WAIT_BUSY;
                end
                T_WAIT_BUSY: begin
                    if (tx_busy)
                        state <= T_WAIT_DONE;
                end
                T_WAIT_DONE: begin
                    if (!tx_busy)
                        state <= T_IDLE;
                end
                default: state <= T_IDLE;
            endcase
        end
    end

`ifdef UART_BUF_ALMOST_FULL_EN
    always_ff @(posedge clk_r or negedge rst_n) begin
        if (!rst_n)
            almost_full <= 1'b0;
        else
            almost_full <= (int'(cnt_nxt) >= AF_LEVEL);
    end
`else
    assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_uart_buf_sched.sv
// Randomized bench for uart_buf_sched: queue-based byte scoreboard plus a reactive transmitter model.
module tb_uart_buf_sched;

    localparam int DW = 8;
    localparam int AW = 10;
`ifdef UART_BUF_ALMOST_FULL_EN
    localparam bit AF_ON = 1'b1;
`else
    localparam bit AF_ON = 1'b0;
`endif

    logic          clk_r = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_wr_req = 1'b0;
    logic [DW-1:0] rx_wr_data = '0;
    logic          rx_wr_ack;
    logic          tx_hold = 1'b0;
    logic          mdl_busy = 1'b0;
    logic          tx_busy;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic [AW:0]   count;
    logic          full, empty, overflow, almost_full;
    logic          ovf_clr = 1'b0;

    int  errs = 0;
    int  checks = 0;
    int  n_start = 0;
    bit  auto_en = 1'b0;
    int  dmax = 3;
    int  lmax = 20;
    logic [DW-1:0] exp_q[$];

    assign tx_busy = tx_hold | mdl_busy;

    always #5 clk_r = ~clk_r;

    uart_buf_sched #(.DW(DW), .AW(AW), .AF_LEVEL(4)) dut (
        .clk_r(clk_r), .rst_n(rst_n),
        .rx_wr_req(rx_wr_req), .rx_wr_data(rx_wr_data), .rx_wr_ack(rx_wr_ack),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .count(count), .full(full), .empty(empty),
        .overflow(overflow), .ovf_clr(ovf_clr), .almost_full(almost_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Every launch must carry the oldest accepted byte and never overlap a busy transmitter.
    initial forever begin
        @(negedge clk_r);
        if (tx_start === 1'b1) begin
            n_start++;
            chk("start_while_busy", 32'(tx_busy), 0);
            if (exp_q.size() == 0)
                chk("start_unexpected", 32'(exp_q.size()), 1);
            else
                chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        end
    end

    initial forever begin
        @(negedge clk_r);
        if (tx_start === 1'b1 && auto_en) begin
            repeat ($urandom_range(0, dmax)) @(posedge clk_r);
            @(posedge clk_r);
            #1 mdl_busy = 1'b1;
            repeat ($urandom_range(1, lmax)) @(posedge clk_r);
            #1 mdl_busy = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wr(input logic [DW-1:0] b, input bit acc);
        @(posedge clk_r);
        #1 rx_wr_req = 1'b1;
        rx_wr_data = b;
        if (acc) exp_q.push_back(b);
        @(posedge clk_r);
        #1 rx_wr_req = 1'b0;
        @(negedge clk_r);
        chk("wr_ack", 32'(rx_wr_ack), 32'(acc));
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || count != 0) && n < budget) begin
            @(negedge clk_r);
            n++;
        end
        chk("drain_timeout", 32'(n < budget), 1);
        repeat (30) @(negedge clk_r);
        chk("drain_empty", 32'(empty), 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_ack"}, 32'(rx_wr_ack), 0);
        chk({tag, "_start"}, 32'(tx_start), 0);
        chk({tag, "_data"}, 32'(tx_data), 0);
        chk({tag, "_af"}, 32'(almost_full), 0);
    endtask

    initial begin
        int n;
        #12;
        chk_reset_vals("rst");
        @(posedge clk_r);
        #1 rst_n = 1'b1;
        auto_en = 1'b1;

        // single byte, launch latency
        wr(8'hA5, 1'b1);
        chk("cnt_one", 32'(count), 1);
        n = 0;
        while (tx_start !== 1'b1 && n < 20) begin
            @(negedge clk_r);
            n++;
        end
        chk("launch_latency", n, 2);
        chk("cnt_after_pop", 32'(count), 0);
        chk("empty_after_pop", 32'(empty), 1);
        wait_drain(200);

        // three bytes with long busy periods
        wr(8'h11, 1'b1);
        wr(8'h22, 1'b1);
        wr(8'h33, 1'b1);
        wait_drain(500);
        chk("n_start_four", n_start, 4);

        // random writes against random transmitter timing
        repeat (40) begin
            repeat ($urandom_range(0, 30)) @(posedge clk_r);
            wr(8'($urandom), 1'b1);
        end
        wait_drain(5000);

        // write in the very cycle the read would start
        tx_hold = 1'b1;
        wr(8'h5C, 1'b1);
        repeat (3) @(negedge clk_r);
        @(posedge clk_r);
        #1 tx_hold = 1'b0;
        rx_wr_req = 1'b1;
        rx_wr_data = 8'hC3;
        exp_q.push_back(8'hC3);
        @(posedge clk_r);
        #1 rx_wr_req = 1'b0;
        @(negedge clk_r);
        chk("conflict_ack", 32'(rx_wr_ack), 1);
        chk("conflict_cnt", 32'(count), 2);
        n = 1;
        while (tx_start !== 1'b1 && n < 20) begin
            @(negedge clk_r);
            n++;
        end
        chk("conflict_latency", n, 3);
        wait_drain(500);

        // fill to full, overflow behaviour
        tx_hold = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            wr(8'(i * 7 + 1), 1'b1);
            if (i == 3) chk("af_at_4", 32'(almost_full), 32'(AF_ON));
        end
        chk("full_set", 32'(full), 1);
        chk("cnt_full", 32'(count), 1024);
        chk("ovf_before", 32'(overflow), 0);
        wr(8'hEE, 1'b0);
        chk("ovf_set", 32'(overflow), 1);
        chk("cnt_still_full", 32'(count), 1024);
        @(posedge clk_r);
        #1 ovf_clr = 1'b1;
        @(posedge clk_r);
        #1 ovf_clr = 1'b0;
        @(negedge clk_r);
        chk("ovf_cleared", 32'(overflow), 0);
        @(posedge clk_r);
        #1 ovf_clr = 1'b1;
        rx_wr_req = 1'b1;
        rx_wr_data = 8'h77;
        @(posedge clk_r);
        #1 ovf_clr = 1'b0;
        rx_wr_req = 1'b0;
        @(negedge clk_r);
        chk("ovf_set_wins_ack", 32'(rx_wr_ack), 0);
        chk("ovf_set_wins", 32'(overflow), 1);
        dmax = 0;
        lmax = 1;
        tx_hold = 1'b0;
        wait_drain(20000);

        // 1023 in, 1023 out, then 5 bytes across the pointer wrap
        tx_hold = 1'b1;
        for (int i = 0; i < 1023; i++) wr(8'($urandom), 1'b1);
        chk("cnt_1023", 32'(count), 1023);
        chk("not_full_1023", 32'(full), 0);
        tx_hold = 1'b0;
        wait_drain(20000);
        for (int i = 0; i < 5; i++) wr(8'(8'hD0 + i), 1'b1);
        wait_drain(500);

        // almost-full on pop, then async reset in the middle of a transfer
        auto_en = 1'b0;
        tx_hold = 1'b1;
        for (int i = 0; i < 4; i++) wr(8'(8'h41 + i), 1'b1);
        chk("af_four", 32'(almost_full), 32'(AF_ON));
        chk("cnt_four", 32'(count), 4);
        @(posedge clk_r);
        #1 tx_hold = 1'b0;
        n = 0;
        while (tx_start !== 1'b1 && n < 20) begin
            @(negedge clk_r);
            n++;
        end
        chk("af_after_pop", 32'(almost_full), 0);
        chk("cnt_three", 32'(count), 3);
        @(posedge clk_r);
        #1 tx_hold = 1'b1;
        wr(8'h99, 1'b1);
        chk("cnt_four_again", 32'(count), 4);
        repeat (2) @(negedge clk_r);
        chk("data_held", 32'(tx_data), 32'h41);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        exp_q.delete();
        @(posedge clk_r);
        #1 rst_n = 1'b1;
        tx_hold = 1'b0;
        n = n_start;
        repeat (20) @(negedge clk_r);
        chk("no_start_after_rst", n_start, n);
        chk("empty_after_rst", 32'(empty), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
